bit_serial_adder: RTL and testbench



---
 rtl/bit_serial_adder.sv | 126 ++++++++++++
 tb/tb_bit_serial_adder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// Bit-serial N-bit adder: latches two operands, adds one bit per clock LSB first,
// and presents the parallel result with a start/busy/done handshake.
// Optional signed-overflow output enabled by defining BIT_SERIAL_ADDER_OVF_EN.
module bit_serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef BIT_SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_load;
   logic             w_shift;
   logic             w_last;

   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-2:0] r_sh;

   logic             w_s;
   logic             w_co;
   logic [WIDTH-1:0] w_sh_nxt;

   // Full-adder cell fed by the operand LSBs and the stored carry
   assign w_s      = r_opa[0] ^ r_opb[0] ^ r_carry;
   assign w_co     = (r_opa[0] & r_opb[0]) | (r_carry & (r_opa[0] ^ r_opb[0]));
   assign w_sh_nxt = {w_s, r_sh};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_shift = 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) begin
               w_last      = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand/carry/count datapath and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opa   <= '0;
         r_opb   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sh    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         done <= w_last;
         if (w_load) begin
            r_opa   <= a;
            r_opb   <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_sh    <= '0;
            busy    <= 1'b1;
         end else if (w_shift) begin
            r_opa   <= r_opa >> 1;
            r_opb   <= r_opb >> 1;
            r_carry <= w_co;
            r_sh    <= w_sh_nxt[WIDTH-1:1];
            // Counter holds on the final bit so it never wraps
            if (!w_last) r_cnt <= r_cnt + CW'(1);
         end
         if (w_last) begin
            sum  <= w_sh_nxt;
            cout <= w_co;
            busy <= 1'b0;
         end
      end
   end

`ifdef BIT_SERIAL_ADDER_OVF_EN
   // Carry into the MSB is the stored carry while the MSB is in the cell
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ovf <= 1'b0;
      else if (w_last) ovf <= r_carry ^ w_co;
   end
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8): directed vector table,
// randomized adds against an arithmetic model, held-start and mid-run reset sequences.
module tb_bit_serial_adder;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef BIT_SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   bit_serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         vc;
      logic [W-1:0] es;
      logic         eco;
      logic         eov;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic scramble();
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
   endtask

   // One complete transaction with latency, busy-length and result checks
   task automatic run_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                          input logic [W-1:0] es, input logic eco, input logic eov,
                          input string tag);
      int lat;
      int nb;
      @(negedge clk);
      start = 1'b1; a = xa; b = xb; cin = xc;
      @(posedge clk); #1;
      start = 1'b0;
      scramble();
      lat = 0;
      nb  = 0;
      while (!done && lat < int'(W) + 4) begin
         if (busy) nb++;
         @(posedge clk); #1;
         lat++;
         scramble();
      end
      chk({tag, " latency"}, 32'(lat), 32'(W));
      chk({tag, " busy_cycles"}, 32'(nb), 32'(W));
      chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, " sum"}, 32'(sum), 32'(es));
      chk({tag, " cout"}, 32'(cout), 32'(eco));
`ifdef BIT_SERIAL_ADDER_OVF_EN
      chk({tag, " ovf"}, 32'(ovf), 32'(eov));
`else
      if (eov === 1'bx) $display("unexpected x in ovf expectation");
`endif
      @(posedge clk); #1;
      chk({tag, " done_pulse"}, 32'(done), 32'd0);
      chk({tag, " held_sum"}, 32'(sum), 32'(es));
   endtask

   initial begin
      logic [W:0] full;
      int         sgn;
      logic       eov;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      int  last_t;
      int  ndone;
      logic prev_done;

      vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[4] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      #12;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset sum",  32'(sum),  32'd0);
      chk("reset cout", 32'(cout), 32'd0);
`ifdef BIT_SERIAL_ADDER_OVF_EN
      chk("reset ovf",  32'(ovf),  32'd0);
`endif
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 7; i++)
         run_add(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].es, vecs[i].eco, vecs[i].eov,
                 $sformatf("vec%0d", i));

      // Randomized adds against plain integer arithmetic
      for (int i = 0; i < 30; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         full = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
         sgn  = int'($signed(ra)) + int'($signed(rb)) + int'(rc);
         eov  = (sgn > 127 || sgn < -128);
         run_add(ra, rb, rc, full[W-1:0], full[W], eov, $sformatf("rnd%0d", i));
      end

      // start held high: requests during SHIFT/DONE ignored, done every W+2 cycles
      @(negedge clk);
      a = 8'h55; b = 8'hAA; cin = 1'b0; start = 1'b1;
      prev_done = 1'b0; ndone = 0; last_t = -1;
      for (int c = 0; c < 35; c++) begin
         @(posedge clk); #1;
         if (done) begin
            chk("held sum", 32'(sum), 32'hFF);
            chk("held cout", 32'(cout), 32'd0);
            chk("held busy_done_excl", 32'(busy), 32'd0);
            if (last_t >= 0) chk("held period", 32'(c - last_t), 32'(W + 2));
            last_t = c;
            ndone++;
         end
         if (prev_done) begin a = 8'h55; b = 8'hAA; cin = 1'b0; end
         else scramble();
         prev_done = done;
      end
      chk("held done_count", 32'(ndone), 32'd3);
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("held final sum", 32'(sum), 32'hFF);

      // Reset mid-transaction after a known result
      run_add(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "pre_rst");
      @(negedge clk);
      start = 1'b1; a = 8'h33; b = 8'h44; cin = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid busy", 32'(busy), 32'd1);
      chk("mid sum_held", 32'(sum), 32'h10);
      rst_n = 1'b0;
      #1;
      chk("abort sum",  32'(sum),  32'd0);
      chk("abort cout", 32'(cout), 32'd0);
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      chk("abort no_done", 32'(ndone), 32'd0);
      run_add(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "timeout");
   end

endmodule
